// File: rtl/team_01_wb_master.sv
// team_01_wb_master
// Wishbone B4 classic single-transfer initiator for team_01.
// It accepts one valid/ready request and runs it as one read or write
// cycle on the arbitrator master port. It then returns a one-cycle response
// pulse that carries the read data and the error status.
//
// Optional feature macro: WB_MASTER_TIMEOUT_EN
//   defined   - a bus wait counter aborts a cycle after TIMEOUT_CYCLES
//               strobe cycles without ACK_I and reports rsp_err = 1.
//   undefined - no counter is built. BUS waits for ACK_I indefinitely and
//               rsp_err is always 0.
module team_01_wb_master
`ifdef WB_MASTER_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255  // legal range 2..65535
)
`endif
(
    input  logic        clk_i,
    input  logic        nrst,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_sel,
    // response side
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    // Wishbone master port
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

`ifdef WB_MASTER_TIMEOUT_EN
    // The last count value before an unacknowledged edge aborts the cycle.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Wait counter register; it is only meaningful while in BUS.
    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            wait_cnt_q <= 16'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // State, Wishbone output and response registers; reset drops the bus at once.
    always_ff @(posedge clk_i or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef WB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_BUS;
                    adr_d   = req_addr;
                    // A read never exposes stale write data on the bus.
                    dat_d   = req_we ? req_wdata : 32'd0;
                    sel_d   = req_sel;
                    we_d    = req_we;
                    cyc_d   = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
                    wait_cnt_d = 16'd0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                // ACK takes priority over a timeout on the same edge.
                if (ACK_I) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : DAT_I;
                    rsp_err_d   = 1'b0;
                    adr_d       = 32'd0;
                    dat_d       = 32'd0;
                    sel_d       = 4'd0;
                    we_d        = 1'b0;
                    cyc_d       = 1'b0;
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == TIMEOUT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                    adr_d       = 32'd0;
                    dat_d       = 32'd0;
                    sel_d       = 4'd0;
                    we_d        = 1'b0;
                    cyc_d       = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`else
                else begin
                    state_d = ST_BUS;
                end
`endif
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                // Unreachable encoding: park safely with the bus released.
                state_d = ST_IDLE;
                adr_d   = 32'd0;
                dat_d   = 32'd0;
                sel_d   = 4'd0;
                we_d    = 1'b0;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_BUS) || (state_q == ST_RESP);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign ADR_O     = adr_q;
    assign DAT_O     = dat_q;
    assign SEL_O     = sel_q;
    assign WE_O      = we_q;
    // STB and CYC share one flop, so STB can never fall without CYC.
    assign STB_O     = cyc_q;
    assign CYC_O     = cyc_q;

endmodule

// File: tb/tb_team_01_wb_master.sv
// Directed bench for team_01_wb_master: a vector table of single transfers
// plus hand-written sequences for reset, back-to-back, stray ACK and
// long-wait behaviour. With WB_MASTER_TIMEOUT_EN it uses TIMEOUT_CYCLES = 4.
module tb_team_01_wb_master;

    logic        clk_i = 1'b0;
    logic        nrst;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] ADR_O, DAT_O, DAT_I;
    logic [3:0]  SEL_O;
    logic        WE_O, STB_O, CYC_O, ACK_I;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

`ifdef WB_MASTER_TIMEOUT_EN
    team_01_wb_master #(.TIMEOUT_CYCLES(4)) dut (
`else
    team_01_wb_master dut (
`endif
        .clk_i(clk_i), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          ack_at;     // strobe cycle on which the slave ACKs, 0 = never
        logic [31:0] sdata;      // slave read data driven with the ACK
        int          exp_stb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs one transfer from IDLE. It must be entered just after a falling edge.
    task automatic run_xfer(input vec_t v, input string tag);
        logic [31:0] exp_dat;
        int          stb_cnt;
        logic        stable_bad;
        logic        early_rsp;
        logic        done;
        exp_dat    = v.we ? v.wdata : 32'd0;
        stb_cnt    = 0;
        stable_bad = 1'b0;
        early_rsp  = 1'b0;
        done       = 1'b0;
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
        req_wdata = v.wdata; req_sel = v.sel;
        @(negedge clk_i);
        req_valid = 1'b0; req_wdata = 32'h5555_AAAA; req_addr = 32'hFFFF_0000;
        for (int c = 0; c < 1100 && !done; c++) begin
            if (CYC_O && STB_O) begin
                stb_cnt++;
                if (ADR_O !== v.addr || DAT_O !== exp_dat || SEL_O !== v.sel || WE_O !== v.we)
                    stable_bad = 1'b1;
                if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1)
                    early_rsp = 1'b1;
                ACK_I = (v.ack_at != 0) && (stb_cnt == v.ack_at);
                DAT_I = ACK_I ? v.sdata : 32'hBAD0_BAD0;
                @(negedge clk_i);
            end else begin
                done = 1'b1;
            end
        end
        ACK_I = 1'b0;
        DAT_I = 32'hBAD1_BAD1;
        chk({tag, "_stb_cycles"}, 32'(stb_cnt), 32'(v.exp_stb));
        chk({tag, "_bus_stable"}, {31'd0, stable_bad}, 32'd0);
        chk({tag, "_no_early_rsp"}, {31'd0, early_rsp}, 32'd0);
        // RESP cycle
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
        chk({tag, "_resp_bus_idle"},
            {23'd0, CYC_O, STB_O, WE_O, SEL_O, |ADR_O, |DAT_O}, 32'd0);
        chk({tag, "_resp_ready_busy"}, {30'd0, req_ready, busy}, 32'd1);
        @(negedge clk_i);
        // back in IDLE: pulse over, data held
        chk({tag, "_pulse_end"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        chk({tag, "_rdata_hold"}, {rsp_rdata[31:1], rsp_rdata[0] ^ rsp_err},
            {v.exp_rdata[31:1], v.exp_rdata[0] ^ v.exp_err});
    endtask

    // Hard stop in case the DUT wedges the stimulus flow.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int stb_cnt, rsp_cnt, r1, r2;
        logic saw_bad;

        // write, 2 wait states
        vecs.push_back('{1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 3, 32'h7777_7777, 3, 32'h0, 1'b0});
        // read, zero wait states
        vecs.push_back('{1'b0, 32'h3000_0004, 32'h0BAD_0BAD, 4'hF, 1, 32'h1234_5678, 1, 32'h1234_5678, 1'b0});
        // write, partial lanes, zero wait: read data must be ignored
        vecs.push_back('{1'b1, 32'h3000_0020, 32'hA5A5_5A5A, 4'h3, 1, 32'hFFFF_FFFF, 1, 32'h0, 1'b0});
        // read, single lane, 3 wait states
        vecs.push_back('{1'b0, 32'h3000_0103, 32'h1111_1111, 4'h1, 4, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1'b0});
`ifdef WB_MASTER_TIMEOUT_EN
        // silent slave: aborted after 4 strobe cycles
        vecs.push_back('{1'b0, 32'h3000_0008, 32'h0, 4'hF, 0, 32'h0, 4, 32'h0, 1'b1});
        // ACK on the 4th strobe cycle wins over the timeout
        vecs.push_back('{1'b0, 32'h3000_000C, 32'h0, 4'hF, 4, 32'h1111_2222, 4, 32'h1111_2222, 1'b0});
        // write timeout
        vecs.push_back('{1'b1, 32'h3000_0014, 32'h0F0F_0F0F, 4'hC, 0, 32'h0, 4, 32'h0, 1'b1});
`else
        // silent slave for 1000 cycles, ACK on cycle 1001
        vecs.push_back('{1'b0, 32'h3000_0030, 32'h0, 4'hF, 1001, 32'h600D_600D, 1001, 32'h600D_600D, 1'b0});
`endif

        nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_sel = 4'd0; DAT_I = 32'd0; ACK_I = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("reset_bus", {24'd0, CYC_O, STB_O, WE_O, SEL_O, |ADR_O}, 32'd0);
        chk("reset_rsp", {29'd0, rsp_valid, rsp_err, busy}, 32'd0);
        chk("reset_data", rsp_rdata | DAT_O, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        nrst = 1'b1;
        @(negedge clk_i);

        // vector table
        foreach (vecs[i]) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // stray ACK in IDLE has no effect
        ACK_I = 1'b1; DAT_I = 32'hDEAD_0000;
        @(negedge clk_i);
        ACK_I = 1'b0;
        chk("stray_ack", {29'd0, req_ready, rsp_valid, CYC_O}, 32'd4);
        @(negedge clk_i);
        chk("stray_ack_after", {29'd0, req_ready, rsp_valid, CYC_O}, 32'd4);

        // back-to-back: request held valid, zero-wait slave, ACK forced outside BUS too
        stb_cnt = 0; rsp_cnt = 0; r1 = -1; r2 = -1; saw_bad = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000_0040; req_sel = 4'hF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk_i);
            if (rsp_valid) begin
                rsp_cnt++;
                if (r1 < 0) r1 = c; else r2 = c;
                if (rsp_rdata !== 32'h0000_00B0 + 32'(rsp_cnt)) saw_bad = 1'b1;
            end
            if (STB_O) begin
                stb_cnt++;
                if (stb_cnt >= 2) req_valid = 1'b0;
                ACK_I = 1'b1;
                DAT_I = 32'h0000_00B0 + 32'(stb_cnt);
            end else begin
                ACK_I = (c > 6);  // stray ACKs once the pair is done
                DAT_I = 32'hBAD2_BAD2;
            end
        end
        ACK_I = 1'b0;
        req_valid = 1'b0;
        chk("b2b_bus_cycles", 32'(stb_cnt), 32'd2);
        chk("b2b_responses", 32'(rsp_cnt), 32'd2);
        chk("b2b_spacing", 32'(r2 - r1), 32'd3);
        chk("b2b_rdata", {31'd0, saw_bad}, 32'd0);

        // asynchronous reset in the middle of a bus cycle
        @(negedge clk_i);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h3000_0050;
        req_wdata = 32'h1357_9BDF; req_sel = 4'hF;
        @(negedge clk_i);
        req_valid = 1'b0;
        @(negedge clk_i);
        chk("midbus_active", {30'd0, CYC_O, STB_O}, 32'd3);
        #2;
        nrst = 1'b0;
        #1;
        chk("midbus_reset_drop", {29'd0, CYC_O, STB_O, rsp_valid}, 32'd0);
        chk("midbus_reset_ready", {30'd0, req_ready, busy}, 32'd2);
        @(negedge clk_i);
        nrst = 1'b1;
        ACK_I = 1'b1;
        @(negedge clk_i);
        ACK_I = 1'b0;
        @(negedge clk_i);
        chk("post_reset_idle", {29'd0, req_ready, rsp_valid, CYC_O}, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
